// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan-code decoder: strips E0/F0/E1 prefixes and queues key events in a FIFO.
// Define PS2_TYPEMATIC_FILTER_EN to suppress typematic repeats of keys already held down.
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_code,
  output logic       out_ext,
  output logic       out_break,
  output logic [7:0] press_count,
  output logic       overflow,
  output logic       seq_error
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   COUNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE    = 1;

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

  // FIFO entries are packed as {ext, break, code}
  state_t      state_q, state_d;
  logic [2:0]  skip_q, skip_d;
  logic [9:0]  mem_q [FIFO_DEPTH];
  logic [9:0]  mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic [9:0]  last_q, last_d;
  logic [7:0]  press_count_q, press_count_d;
  logic        overflow_q, overflow_d;
  logic        seq_error_q, seq_error_d;
`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [511:0] pressed_q, pressed_d;
`endif

  logic       dec_emit, dec_ext, dec_brk, ev_emit;
  logic       fifo_full, push, pop;

  always_comb begin
    state_d       = state_q;
    skip_d        = skip_q;
    seq_error_d   = seq_error_q;
    overflow_d    = overflow_q;
    press_count_d = press_count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    last_d        = last_q;
    mem_d         = mem_q;
    dec_emit      = 1'b0;
    dec_ext       = 1'b0;
    dec_brk       = 1'b0;

    if (in_valid) begin
      if (in_data == 8'h00 || in_data == 8'hFF) begin
        seq_error_d = 1'b1;
        state_d     = IDLE;
        skip_d      = 3'd0;
      end else begin
        case (state_q)
          IDLE: begin
            case (in_data)
              8'hE0: state_d = EXT;
              8'hF0: state_d = BRK;
              8'hE1: begin
                state_d  = PAUSE;
                skip_d   = 3'd7;
                dec_emit = 1'b1;
                dec_ext  = 1'b1;
              end
              default: dec_emit = 1'b1;
            endcase
          end
          EXT: begin
            case (in_data)
              8'hF0: state_d = EXT_BRK;
              8'hE0: state_d = EXT;
              default: begin
                dec_emit = 1'b1;
                dec_ext  = 1'b1;
                state_d  = IDLE;
              end
            endcase
          end
          BRK: begin
            case (in_data)
              8'hE0: state_d = EXT_BRK;
              8'hF0: state_d = BRK;
              default: begin
                dec_emit = 1'b1;
                dec_brk  = 1'b1;
                state_d  = IDLE;
              end
            endcase
          end
          EXT_BRK: begin
            if (in_data != 8'hE0 && in_data != 8'hF0) begin
              dec_emit = 1'b1;
              dec_ext  = 1'b1;
              dec_brk  = 1'b1;
              state_d  = IDLE;
            end
          end
          PAUSE: begin
            if (skip_q <= 3'd1) begin
              skip_d  = 3'd0;
              state_d = IDLE;
            end else begin
              skip_d = skip_q - 3'd1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end

    ev_emit = dec_emit;
`ifdef PS2_TYPEMATIC_FILTER_EN
    // The pause event bypasses the bitmap entirely
    pressed_d = pressed_q;
    if (dec_emit && !(state_q == IDLE && in_data == 8'hE1)) begin
      if (dec_brk) begin
        pressed_d[{dec_ext, in_data}] = 1'b0;
      end else if (pressed_q[{dec_ext, in_data}]) begin
        ev_emit = 1'b0;
      end else begin
        pressed_d[{dec_ext, in_data}] = 1'b1;
      end
    end
`endif

    if (ev_emit && !dec_brk) begin
      press_count_d = press_count_q + 8'd1;
    end

    fifo_full = (count_q == FULL_COUNT);
    pop       = (count_q != '0) && out_ready;
    push      = ev_emit && (!fifo_full || pop);
    if (ev_emit && fifo_full && !pop) begin
      overflow_d = 1'b1;
    end

    if (pop) begin
      last_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (push) begin
      mem_d[wr_ptr_q] = {dec_ext, dec_brk, in_data};
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (push && !pop) begin
      count_d = count_q + COUNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - COUNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= IDLE;
      skip_q        <= 3'd0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      last_q        <= '0;
      press_count_q <= 8'd0;
      overflow_q    <= 1'b0;
      seq_error_q   <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
      pressed_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      skip_q        <= skip_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      last_q        <= last_d;
      press_count_q <= press_count_d;
      overflow_q    <= overflow_d;
      seq_error_q   <= seq_error_d;
      mem_q         <= mem_d;
`ifdef PS2_TYPEMATIC_FILTER_EN
      pressed_q     <= pressed_d;
`endif
    end
  end

  // An empty FIFO keeps showing the most recently popped event
  assign out_valid   = (count_q != '0);
  assign {out_ext, out_break, out_code} = out_valid ? mem_q[rd_ptr_q] : last_q;
  assign press_count = press_count_q;
  assign overflow    = overflow_q;
  assign seq_error   = seq_error_q;

endmodule

// File: doc/ps2_scancode_decoder.md
PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, meaning event FIFO entries (power of two, 2..16).
REQ-002 clk  input  1  system clock, all logic on rising edge.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  one-cycle strobe, in_data holds a validated PS/2 byte; may assert on consecutive cycles; no backpressure.
REQ-005 in_data  input  8  received scan-code byte.
REQ-006 out_valid  output  1  FIFO non-empty, head event presented.
REQ-007 out_ready  input  1  consumer accepts head event when out_valid&&out_ready.
REQ-008 out_code  output  8  head event key code (prefixes stripped).
REQ-009 out_ext  output  1  head event carried E0 prefix (or is the pause event).
REQ-010 out_break  output  1  head event is release (1) or press (0).
REQ-011 press_count  output  8  number of decoded press events, wraps 255->0.
REQ-012 overflow  output  1  sticky, an event was dropped because FIFO full.
REQ-013 seq_error  output  1  sticky, 0x00 or 0xFF byte received.

Function
REQ-014 Decoder FSM states SHALL be IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 then F0 seen), PAUSE (skipping).
REQ-015 IDLE: 0xE0->EXT; 0xF0->BRK; 0xE1->PAUSE with skip counter 7 and emit event {code=0xE1,ext=1,break=0}; other byte->emit {byte,0,0}, stay IDLE.
REQ-016 EXT: 0xF0->EXT_BRK; 0xE0 stays EXT; other byte->emit {byte,1,0}, ->IDLE.
REQ-017 BRK: any byte except 0xE0/0xF0 ->emit {byte,0,1}, ->IDLE; 0xE0 ->EXT_BRK; 0xF0 stays BRK.
REQ-018 EXT_BRK: any byte except 0xE0/0xF0 ->emit {byte,1,1}, ->IDLE; 0xE0/0xF0 stay EXT_BRK.
REQ-019 PAUSE: each in_valid decrements skip counter, no events; counter reaching 0 on that byte ->IDLE.
REQ-020 Byte 0x00 or 0xFF in any state SHALL set seq_error, emit nothing, force IDLE (including out of PAUSE).
REQ-021 State advances only on cycles with in_valid=1; otherwise holds.
REQ-022 Emitted event SHALL be written into FIFO at the clock edge that samples the completing byte; out_valid rises the following cycle when FIFO was empty (latency 1).
REQ-023 FIFO full and pop in same cycle: pop and push both SHALL occur, no drop.
REQ-024 FIFO full without pop: event dropped, overflow set, FIFO contents unchanged.
REQ-025 Empty FIFO: out_valid=0, out_code/out_ext/out_break hold last-popped values (0 after reset); out_ready ignored.
REQ-026 press_count SHALL increment on every emitted press event (break=0), whether or not it was dropped by the FIFO.
REQ-027 FIFO order strictly first-in first-out; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-028 resetn=0 at a clock edge SHALL force IDLE, skip counter 0, FIFO empty, out_valid 0, out_code 0, out_ext 0, out_break 0, press_count 0, overflow 0, seq_error 0, pressed bitmap cleared.
REQ-029 Reset mid-sequence (after E0/F0/E1) SHALL discard partial prefix; next byte decodes from IDLE.
REQ-030 in_valid during reset SHALL be ignored.

Configuration
REQ-031 Macro PS2_TYPEMATIC_FILTER_EN: when defined, a 512-bit pressed bitmap indexed {ext,code} SHALL be kept; a press on an already-set key is suppressed (no event, no press_count increment); a press sets the bit; a release clears it and is always emitted; the pause event is never filtered.
REQ-032 Without PS2_TYPEMATIC_FILTER_EN: no bitmap; every decoded press, including typematic repeats, is emitted and counted.

Verification
REQ-033 Bytes 0x1C,0xF0,0x1C -> events {1C,0,0},{1C,0,1}; press_count=1.
REQ-034 Bytes 0xE0,0x75,0xE0,0xF0,0x75 -> events {75,1,0},{75,1,1}; press_count=1.
REQ-035 Bytes 0x1C x3 then 0xF0,0x1C -> with filter: 2 events, press_count=1; without: 4 events, press_count=3.
REQ-036 out_ready=0, 9 distinct press bytes with FIFO_DEPTH=8 -> 8 events retained in order, overflow=1, press_count=9; then out_ready=1 drains 8 then out_valid=0.
REQ-037 Bytes 0xE1,0x14,0x77,0xE1,0xF0,0x14,0xF0,0x77,0x1C -> events {E1,1,0},{1C,0,0}; bytes 0xE0 then resetn pulse then 0x75 -> event {75,0,0}; byte 0xFF -> seq_error=1, no event.
